// File: rtl/vsc_pkg.sv
// Shared types, opcode/state encodings and the datapath ALU for the VSC core.
// Imported by the interface, the interrupt arbiter and the core.
package vsc_pkg;

  localparam int ADDR_W = 14;
  localparam int DATA_W = 32;
  localparam int IDX_W  = 3;

  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [DATA_W-1:0] word_t;
  typedef logic [IDX_W-1:0]  idx_t;

  typedef enum logic [2:0] {
    OP_ADD, OP_NAND, OP_SRL, OP_LT, OP_CP, OP_CPI, OP_BZJ, OP_MUL
  } op_e;

  typedef enum logic [2:0] {
    FETCH, DECODE, RDA, RDB, EXEC, IRQ_VEC, IRQ_SAVE
  } state_e;

  // Copy-type opcodes fall through to the default and return b unchanged.
  function automatic word_t alu(input op_e op, input word_t a, input word_t b);
    word_t r;
    r = b;
    case (op)
      OP_ADD:  r = a + b;
      OP_NAND: r = ~(a & b);
      OP_SRL: begin
        if (b < 32)      r = a >> b[4:0];
        else if (b < 64) r = a << b[4:0];
        else             r = '0;
      end
      OP_LT:   r = {{(DATA_W-1){1'b0}}, (a < b)};
      OP_MUL:  r = word_t'(a[15:0]) * word_t'(b[15:0]);
      default: r = b;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/vsc_cpu_vec_irq_if.sv
// Single-port synchronous RAM bus between the core (master) and the RAM (slave).
// Read data is valid one cycle after the address is presented.
interface vsc_cpu_vec_irq_if;
  import vsc_pkg::*;

  logic  wrEn;
  addr_t addr_toRAM;
  word_t data_toRAM;
  word_t data_fromRAM;

  modport master (
    output wrEn, addr_toRAM, data_toRAM,
    input  data_fromRAM
  );

  modport slave (
    input  wrEn, addr_toRAM, data_toRAM,
    output data_fromRAM
  );

endinterface

// File: rtl/vsc_irq_arb.sv
// Interrupt front end: rising-edge detect, sticky pending bits, fixed-priority
// pick (index 0 highest) and one-hot acknowledge of the line being vectored.
module vsc_irq_arb
  import vsc_pkg::*;
#(
  parameter int NUM_IRQ = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_IRQ-1:0] irq_i,
  input  logic [NUM_IRQ-1:0] irq_en_i,
  input  logic               ack_stb_i,
  input  idx_t               ack_idx_i,
  output logic               req_o,
  output idx_t               pick_o,
  output logic [NUM_IRQ-1:0] ack_o
);

  logic [NUM_IRQ-1:0] irq_q;
  logic [NUM_IRQ-1:0] pending_q;
  logic [NUM_IRQ-1:0] pending_d;
  logic [NUM_IRQ-1:0] active;

  assign active = pending_q & irq_en_i;
  assign req_o  = |active;

  // A fresh edge in the same cycle as the ack keeps the line pending.
  for (genvar gi = 0; gi < NUM_IRQ; gi++) begin : g_line
    assign ack_o[gi]     = ack_stb_i && (ack_idx_i == idx_t'(gi));
    assign pending_d[gi] = (pending_q[gi] & ~ack_o[gi]) | (irq_i[gi] & ~irq_q[gi]);
  end

  always_comb begin
    pick_o = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (active[i]) pick_o = idx_t'(i);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irq_q     <= '0;
      pending_q <= '0;
    end else begin
      irq_q     <= irq_i;
      pending_q <= pending_d;
    end
  end

endmodule

// File: rtl/vsc_cpu_vec_irq.sv
// Multi-cycle VerySimpleCPU core over one synchronous RAM, with a vectored,
// non-nesting interrupt unit. Bus outputs are combinational from the state.
module vsc_cpu_vec_irq
  import vsc_pkg::*;
#(
  parameter int NUM_IRQ   = 4,
  parameter int VEC_BASE  = 8,
  parameter int SAVE_ADDR = 6,
  parameter int RST_PC    = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  vsc_cpu_vec_irq_if.master     mem_bus,
  input  logic [NUM_IRQ-1:0]    irq,
  input  logic [NUM_IRQ-1:0]    irq_en,
  output logic [NUM_IRQ-1:0]    irq_ack,
  output logic                  in_isr
);

  state_e st_q, st_d;
  addr_t  pc_q, pc_d;
  word_t  iw_q, iw_d;
  word_t  ra_q, ra_d;
  word_t  rb_q, rb_d;
  idx_t   idx_q, idx_d;
  logic   in_isr_q, in_isr_d;

  logic   we;
  addr_t  addr;
  word_t  wdata;
  logic   ack_stb;
  logic   done;
  logic   irq_req;
  idx_t   irq_pick;

  op_e    op;
  logic   imm;
  addr_t  fa, fb, pc_inc;
  word_t  rdata, bzext;

  assign rdata  = mem_bus.data_fromRAM;
  assign op     = op_e'(iw_q[31:29]);
  assign imm    = iw_q[28];
  assign fa     = iw_q[27:14];
  assign fb     = iw_q[13:0];
  assign bzext  = word_t'(fb);
  assign pc_inc = pc_q + addr_t'(1);

  vsc_irq_arb #(.NUM_IRQ(NUM_IRQ)) u_arb (
    .clk       (clk),
    .rst_n     (rst_n),
    .irq_i     (irq),
    .irq_en_i  (irq_en),
    .ack_stb_i (ack_stb),
    .ack_idx_i (idx_q),
    .req_o     (irq_req),
    .pick_o    (irq_pick),
    .ack_o     (irq_ack)
  );

  always_comb begin
    st_d     = st_q;
    pc_d     = pc_q;
    iw_d     = iw_q;
    ra_d     = ra_q;
    rb_d     = rb_q;
    idx_d    = idx_q;
    in_isr_d = in_isr_q;
    we       = 1'b0;
    addr     = pc_q;
    wdata    = '0;
    ack_stb  = 1'b0;
    done     = 1'b0;

    case (st_q)
      FETCH: begin
        addr = pc_q;
        st_d = DECODE;
      end
      DECODE: begin
        iw_d = rdata;
        addr = rdata[27:14];
        st_d = RDA;
      end
      RDA: begin
        ra_d = rdata;
        addr = fb;
        // Immediate forms (except CPIi) finish here with *A on the read port.
        if (imm && op != OP_CPI) begin
          done = 1'b1;
          pc_d = pc_inc;
          if (op == OP_BZJ) begin
            pc_d = rdata[13:0] + fb;
          end else begin
            we    = 1'b1;
            addr  = fa;
            wdata = alu(op, rdata, bzext);
          end
        end else begin
          st_d = (op == OP_CPI) ? RDB : EXEC;
        end
      end
      RDB: begin
        rb_d = rdata;
        addr = rdata[13:0];
        st_d = EXEC;
      end
      EXEC: begin
        done = 1'b1;
        pc_d = pc_inc;
        addr = fa;
        if (op == OP_BZJ) begin
          if (rdata == '0) pc_d = ra_q[13:0];
          if (fa == addr_t'(SAVE_ADDR)) in_isr_d = 1'b0;
        end else if (op == OP_CPI && imm) begin
          we    = 1'b1;
          addr  = ra_q[13:0];
          wdata = rb_q;
        end else begin
          we    = 1'b1;
          wdata = alu(op, ra_q, rdata);
        end
      end
      IRQ_VEC: begin
        addr     = addr_t'(VEC_BASE) + addr_t'(idx_q);
        ack_stb  = 1'b1;
        in_isr_d = 1'b1;
        st_d     = IRQ_SAVE;
      end
      IRQ_SAVE: begin
        we    = 1'b1;
        addr  = addr_t'(SAVE_ADDR);
        wdata = word_t'(pc_q);
        pc_d  = rdata[13:0];
        st_d  = FETCH;
      end
      default: st_d = FETCH;
    endcase

    // Using in_isr_d lets a pending line preempt the fetch right after RETI.
    if (done) begin
      if (irq_req && !in_isr_d) begin
        st_d  = IRQ_VEC;
        idx_d = irq_pick;
      end else begin
        st_d = FETCH;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q     <= FETCH;
      pc_q     <= addr_t'(RST_PC);
      iw_q     <= '0;
      ra_q     <= '0;
      rb_q     <= '0;
      idx_q    <= '0;
      in_isr_q <= 1'b0;
    end else begin
      st_q     <= st_d;
      pc_q     <= pc_d;
      iw_q     <= iw_d;
      ra_q     <= ra_d;
      rb_q     <= rb_d;
      idx_q    <= idx_d;
      in_isr_q <= in_isr_d;
    end
  end

  assign mem_bus.wrEn       = we;
  assign mem_bus.addr_toRAM = addr;
  assign mem_bus.data_toRAM = wdata;
  assign in_isr             = in_isr_q;

endmodule
